lsu_dmem_port: RTL

Load/store unit between the controller/ALU stage and the per-core data cache controller. Consumes the registered decode controls (`rd_en`, `wr_en`, `mask`) and the ALU address, and runs a single-outstanding request/acknowledge transaction to the data cache. It stalls the pipeline until the transaction completes, then returns sign- or zero-extended load data to writeback. It also flags misaligned or illegal accesses and cache timeouts.

---
 rtl/lsu_dmem_port.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lsu_dmem_port.sv
// Load/store port between the execute stage and the data cache: one outstanding
// request/acknowledge transaction, lane steering of store data and load extension.
module lsu_dmem_port #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [2:0]  mask,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    output logic        lsu_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_err,
    output logic        timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [1:0]  off;
    logic [2:0]  mask_q;

    logic        present;
    logic        legal;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] lane_word;
    logic [31:0] extracted;

    assign present = rd_en | wr_en;

    always_comb begin
        legal = 1'b0;
        case (mask)
            3'd0, 3'd4: legal = 1'b1;
            3'd1, 3'd5: legal = !alu_out[0];
            3'd2:       legal = (alu_out[1:0] == 2'b00);
            default:    legal = 1'b0;
        endcase
    end

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = store_data;
        case (mask[1:0])
            2'd0: begin
                be_next    = 4'b0001 << alu_out[1:0];
                wdata_next = {4{store_data[7:0]}};
            end
            2'd1: begin
                be_next    = alu_out[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{store_data[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = store_data;
            end
        endcase
        if (!wr_en) begin
            wdata_next = 32'd0;
        end
    end

    // Shift the addressed lane down to bit 0, then extend by the latched size code.
    assign lane_word = mem_rdata >> {off, 3'b000};

    always_comb begin
        extracted = lane_word;
        case (mask_q)
            3'd0:    extracted = {{24{lane_word[7]}}, lane_word[7:0]};
            3'd1:    extracted = {{16{lane_word[15]}}, lane_word[15:0]};
            3'd4:    extracted = {24'd0, lane_word[7:0]};
            3'd5:    extracted = {16'd0, lane_word[15:0]};
            default: extracted = lane_word;
        endcase
    end

    assign lsu_stall = !reset & (((state == IDLE) & present & legal) | (state == REQ));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            off        <= 2'd0;
            mask_q     <= 3'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'd0;
            load_data  <= 32'd0;
            load_valid <= 1'b0;
            access_err <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            access_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (present && legal) begin
                        mem_req   <= 1'b1;
                        mem_we    <= wr_en;
                        mem_addr  <= {alu_out[31:2], 2'b00};
                        mem_be    <= be_next;
                        mem_wdata <= wdata_next;
                        off       <= alu_out[1:0];
                        mask_q    <= mask;
                        wait_cnt  <= 8'd0;
                        state     <= REQ;
                    end else if (present) begin
                        access_err <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        if (!mem_we) begin
                            load_data  <= extracted;
                            load_valid <= 1'b1;
                        end
                    end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
                        // Abandoned request: loads still complete, with zero data.
                        mem_req <= 1'b0;
                        timeout <= 1'b1;
                        state   <= DONE;
                        if (!mem_we) begin
                            load_data  <= 32'd0;
                            load_valid <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
